// File: rtl/ir_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ir_receiver_pkg
// Description : Shared types and constants for the IR command receiver.
//               FSM state encoding, register offsets within the block's
//               address window, STATUS bit positions and the duration
//               counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package ir_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_START_MARK = 2'd1,
    ST_SPACE      = 2'd2,
    ST_DATA_MARK  = 2'd3
  } ir_state_t;

  // Register offsets from BASE_ADDR
  localparam logic [7:0] c_CMD_OFS    = 8'd0;
  localparam logic [7:0] c_STATUS_OFS = 8'd1;

  // STATUS register bit positions
  localparam int c_STAT_VALID = 0;
  localparam int c_STAT_ERR   = 1;
  localparam int c_STAT_OVR   = 2;

  // Mark/space duration counter width (saturates at 1023 ticks)
  localparam int c_DUR_W = 10;

endpackage : ir_receiver_pkg
`default_nettype wire

// File: rtl/ir_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : ir_pulse_timer
// Description : Front end of the IR receiver. Synchronises the raw receiver
//               output, detects mark start/end edges and measures the time
//               since the last edge in prescaled ticks.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_ir_in        raw demodulated IR input (low = mark), asynchronous
//   o_mark_start   one-cycle pulse: synchronised input fell
//   o_mark_end     one-cycle pulse: synchronised input rose
//   o_duration     ticks elapsed since the last edge, saturating
// ============================================================================
module ir_pulse_timer
  import ir_receiver_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ir_in,
  output logic               o_mark_start,
  output logic               o_mark_end,
  output logic [c_DUR_W-1:0] o_duration
);

  localparam int                c_TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

  // [0],[1] form the synchroniser; [2] is the previous synchronised value
  // used for edge detection. Reset to 1 = line idle (no carrier).
  logic [2:0]          r_sync;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_DUR_W-1:0]  r_dur;

  logic w_tick;
  logic w_edge;

  assign w_tick       = (r_tick_cnt == c_TICK_LAST);
  assign o_mark_start = r_sync[2] & ~r_sync[1];
  assign o_mark_end   = ~r_sync[2] & r_sync[1];
  assign w_edge       = o_mark_start | o_mark_end;
  assign o_duration   = r_dur;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= 3'b111;
      r_tick_cnt <= '0;
      r_dur      <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_ir_in};

      if (w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

      // Edge clears take priority; the FSM samples r_dur in the edge cycle,
      // so the value it compares is the full length of the finished interval.
      if (w_edge) begin
        r_dur <= '0;
      end else if (w_tick && (r_dur != '1)) begin
        r_dur <= r_dur + 1'b1;
      end
    end
  end

endmodule : ir_pulse_timer
`default_nettype wire

// File: rtl/ir_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ir_receiver
// Description : Bus-mapped IR car-command receiver. Decodes one packet
//               (start mark, select mark, right/left/backward/forward data
//               marks) into CMD, tracks VALID/ERR/OVR in STATUS and raises
//               an interrupt on every completed packet.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk                  system clock
//   i_rst_n                asynchronous active-low reset
//   i_ir_in                demodulated IR input (low = mark), asynchronous
//   io_bus_data            shared 8-bit data bus, driven only for our reads
//   i_bus_addr             bus address
//   i_bus_we               bus write enable
//   o_bus_interrupt_raise  packet-received interrupt
//   i_bus_interrupt_ack    interrupt acknowledge
// ============================================================================
module ir_receiver
  import ir_receiver_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hA0,
  parameter int         TICK_DIV  = 1000,
  parameter int         START_MIN = 400,
  parameter int         ONE_MIN   = 95,
  parameter int         ZERO_MIN  = 40,
  parameter int         GAP_MAX   = 150
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ir_in,
  inout  wire  [7:0] io_bus_data,
  input  logic [7:0] i_bus_addr,
  input  logic       i_bus_we,
  output logic       o_bus_interrupt_raise,
  input  logic       i_bus_interrupt_ack
);

  localparam logic [7:0]         c_CMD_ADDR    = BASE_ADDR + c_CMD_OFS;
  localparam logic [7:0]         c_STATUS_ADDR = BASE_ADDR + c_STATUS_OFS;
  localparam logic [c_DUR_W-1:0] c_START_MIN   = c_DUR_W'(START_MIN);
  localparam logic [c_DUR_W-1:0] c_ONE_MIN     = c_DUR_W'(ONE_MIN);
  localparam logic [c_DUR_W-1:0] c_ZERO_MIN    = c_DUR_W'(ZERO_MIN);
  localparam logic [c_DUR_W-1:0] c_GAP_MAX     = c_DUR_W'(GAP_MAX);

  logic               w_mark_start;
  logic               w_mark_end;
  logic [c_DUR_W-1:0] w_dur;

  ir_pulse_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_pulse_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ir_in      (i_ir_in),
    .o_mark_start (w_mark_start),
    .o_mark_end   (w_mark_end),
    .o_duration   (w_dur)
  );

  ir_state_t  r_state;
  logic [2:0] r_bit_cnt;   // 0 = select mark, 1..4 = data marks
  logic [3:0] r_shift;
  logic [3:0] r_cmd;
  logic       r_valid;
  logic       r_err;
  logic       r_ovr;
  logic       r_raise;
  logic       r_bus_oe;
  logic [7:0] r_bus_dout;

  logic       w_short;
  logic       w_long;
  logic       w_gap;
  logic [3:0] w_shift_next;
  logic       w_rd_cmd;
  logic       w_rd_status;
  logic       w_status_wr;
  logic [7:0] w_status;

  assign w_short      = (w_dur < c_ZERO_MIN);
  assign w_long       = (w_dur >= c_START_MIN);
  assign w_gap        = (w_dur >= c_GAP_MAX);
  assign w_shift_next = {r_shift[2:0], (w_dur >= c_ONE_MIN)};

  assign w_rd_cmd    = !i_bus_we && (i_bus_addr == c_CMD_ADDR);
  assign w_rd_status = !i_bus_we && (i_bus_addr == c_STATUS_ADDR);
  assign w_status_wr =  i_bus_we && (i_bus_addr == c_STATUS_ADDR);

  always_comb begin
    w_status               = '0;
    w_status[c_STAT_VALID] = r_valid;
    w_status[c_STAT_ERR]   = r_err;
    w_status[c_STAT_OVR]   = r_ovr;
  end

  // Decoder FSM plus the registers it owns. The STATUS clear and interrupt
  // acknowledge are applied first so that a same-cycle packet event, which
  // is assigned later in the block, overrides them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_cmd     <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_raise   <= 1'b0;
    end else begin
      if (w_status_wr) begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
        r_ovr   <= 1'b0;
      end
      if (i_bus_interrupt_ack) begin
        r_raise <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_mark_start) begin
            r_state <= ST_START_MARK;
          end
        end

        ST_START_MARK: begin
          if (w_mark_end) begin
            if (w_long) begin
              r_state   <= ST_SPACE;
              r_bit_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        ST_SPACE: begin
          if (w_mark_start) begin
            r_state <= ST_DATA_MARK;
          end else if (w_gap) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        ST_DATA_MARK: begin
          if (w_mark_end) begin
            if (w_short) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else if (w_long) begin
              // A start mark inside a packet restarts decoding; only an
              // interrupted packet (some marks already taken) is an error.
              if (r_bit_cnt != 3'd0) begin
                r_err <= 1'b1;
              end
              r_bit_cnt <= '0;
              r_state   <= ST_SPACE;
            end else if (r_bit_cnt == 3'd4) begin
              r_cmd     <= w_shift_next;
              r_shift   <= w_shift_next;
              r_ovr     <= r_ovr | r_valid;
              r_valid   <= 1'b1;
              r_raise   <= 1'b1;
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end else begin
              if (r_bit_cnt != 3'd0) begin
                r_shift <= w_shift_next;
              end
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_state   <= ST_SPACE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data and output enable are registered: data appears one cycle
  // after the address is presented.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_oe   <= 1'b0;
      r_bus_dout <= '0;
    end else begin
      r_bus_oe   <= w_rd_cmd | w_rd_status;
      r_bus_dout <= w_rd_status ? w_status : {4'b0000, r_cmd};
    end
  end

  assign io_bus_data           = r_bus_oe ? r_bus_dout : 8'hzz;
  assign o_bus_interrupt_raise = r_raise;

endmodule : ir_receiver
`default_nettype wire

// File: tb/tb_ir_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_receiver
// Description : Self-checking bench for ir_receiver. Directed packet
//               scenarios followed by randomised packets, compared against
//               a packet-level model of CMD / STATUS / interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_receiver;

  localparam int         TD       = 2;      // short tick keeps runtime small
  localparam logic [7:0] BASE     = 8'hA0;
  localparam int         ONE_T    = 95;
  localparam logic [7:0] IDLE_BUS = 8'hFF;  // released bus reads as pull-ups

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ir    = 1'b1;
  logic       we    = 1'b0;
  logic       ack   = 1'b0;
  logic [7:0] addr  = 8'h00;
  wire  [7:0] bus;
  wire        raise;

  int checks   = 0;
  int failures = 0;

  // Packet-level reference state
  logic [3:0] m_cmd   = 4'h0;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_raise = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_pullup
    pullup (bus[g]);
  end

  ir_receiver #(
    .BASE_ADDR (BASE),
    .TICK_DIV  (TD)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_ir_in               (ir),
    .io_bus_data           (bus),
    .i_bus_addr            (addr),
    .i_bus_we              (we),
    .o_bus_interrupt_raise (raise),
    .i_bus_interrupt_ack   (ack)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] decode(input int r, input int l, input int b, input int f);
    return {r >= ONE_T, l >= ONE_T, b >= ONE_T, f >= ONE_T};
  endfunction

  task automatic level(input logic v, input int ticks);
    @(negedge clk);
    ir = v;
    repeat (ticks * TD - 1) @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a;
    we   = 1'b0;
    @(negedge clk);
    d    = bus;
    addr = 8'h00;
  endtask

  task automatic bus_write(input logic [7:0] a);
    @(negedge clk);
    addr = a;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    addr = 8'h00;
  endtask

  task automatic clear_status();
    bus_write(BASE + 8'd1);
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    m_raise = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    bus_read(BASE, d);
    check({tag, "_cmd"}, d, {4'h0, m_cmd});
    bus_read(BASE + 8'd1, d);
    check({tag, "_status"}, d, {5'b0, m_ovr, m_err, m_valid});
    @(negedge clk);
    check({tag, "_bus_release"}, bus, IDLE_BUS);
    check({tag, "_raise"}, {7'b0, raise}, {7'b0, m_raise});
  endtask

  // Select mark, four data marks and the completion window. mode 1 = ACK
  // and mode 2 = STATUS clear, both in the cycle the packet completes.
  task automatic send_body(input int sel, input int r, input int l, input int b,
                           input int f, input int sp, input int mode);
    level(1'b0, sel); level(1'b1, sp);
    level(1'b0, r);   level(1'b1, sp);
    level(1'b0, l);   level(1'b1, sp);
    level(1'b0, b);   level(1'b1, sp);
    level(1'b0, f);
    @(negedge clk);
    ir = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("raise_not_early", {7'b0, raise}, {7'b0, m_raise});
    if (mode == 1) ack = 1'b1;
    if (mode == 2) begin
      addr = BASE + 8'd1;
      we   = 1'b1;
    end
    @(posedge clk);
    #1;
    ack  = 1'b0;
    we   = 1'b0;
    addr = 8'h00;
    check("raise_latency", {7'b0, raise}, 8'h01);
    m_cmd = decode(r, l, b, f);
    if (mode == 2) begin
      m_valid = 1'b1;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_ovr   = m_ovr | m_valid;
      m_valid = 1'b1;
    end
    m_raise = 1'b1;
    level(1'b1, 30);
  endtask

  task automatic send_packet(input int st, input int sel, input int r, input int l,
                             input int b, input int f, input int sp, input int mode);
    level(1'b0, st);
    level(1'b1, sp);
    send_body(sel, r, l, b, f, sp, mode);
  endtask

  task automatic send_head(input int sp);
    level(1'b0, 530); level(1'b1, sp);
    level(1'b0, 130); level(1'b1, sp);
  endtask

  initial begin
    logic [7:0] d;
    int         kind, mode, st, sel, sp, r, l, b, f;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("rst_raise", {7'b0, raise}, 8'h00);
    check("rst_bus_release", bus, IDLE_BUS);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_regs("reset");

    // ---------------- clean packet 09 ----------------
    send_packet(530, 130, 130, 61, 61, 130, 25, 0);
    bus_read(BASE, d);
    check("pkt1_cmd_lit", d, 8'h09);
    bus_read(BASE + 8'd1, d);
    check("pkt1_status_lit", d, 8'h01);
    check_regs("pkt1");
    ack_pulse();
    check("pkt1_ack", {7'b0, raise}, 8'h00);

    // ---------------- second packet 06, ACK collides with completion ----------------
    send_packet(530, 130, 61, 130, 130, 61, 25, 1);
    bus_read(BASE, d);
    check("pkt2_cmd_lit", d, 8'h06);
    bus_read(BASE + 8'd1, d);
    check("pkt2_status_lit", d, 8'h05);
    check_regs("pkt2");
    bus_write(BASE);               // CMD is read-only
    check_regs("cmd_write_ignored");
    clear_status();
    bus_read(BASE + 8'd1, d);
    check("pkt2_cleared_lit", d, 8'h00);
    ack_pulse();

    // ---------------- glitch after select ----------------
    send_head(25);
    level(1'b0, 20);
    level(1'b1, 30);
    m_err = 1'b1;
    bus_read(BASE + 8'd1, d);
    check("glitch_status_lit", d, 8'h02);
    check_regs("glitch");
    clear_status();

    // ---------------- long space mid-packet ----------------
    send_head(25);
    level(1'b0, 130); level(1'b1, 25);
    level(1'b0, 61);  level(1'b1, 200);
    m_err = 1'b1;
    check_regs("gap");
    send_packet(530, 130, 130, 130, 61, 61, 25, 0);
    bus_read(BASE, d);
    check("gap_next_cmd_lit", d, 8'h0C);
    check_regs("gap_next");
    clear_status();
    ack_pulse();

    // ---------------- start mark injected after two data bits ----------------
    send_head(25);
    level(1'b0, 130); level(1'b1, 25);
    level(1'b0, 61);  level(1'b1, 25);
    level(1'b0, 530); level(1'b1, 25);
    m_err = 1'b1;
    send_body(130, 61, 61, 130, 130, 25, 0);
    check_regs("restart");

    // ---------------- reset during third data mark ----------------
    send_head(25);
    level(1'b0, 130); level(1'b1, 25);
    level(1'b0, 61);  level(1'b1, 25);
    @(negedge clk);
    ir = 1'b0;
    repeat (40 * TD) @(negedge clk);
    rst_n = 1'b0;
    m_cmd = 4'h0; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_raise = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_raise", {7'b0, raise}, 8'h00);
    check("midrst_bus_release", bus, IDLE_BUS);
    rst_n = 1'b1;
    repeat (60 * TD) @(negedge clk);
    level(1'b1, 25);
    level(1'b0, 130);
    level(1'b1, 30);
    check_regs("midrst");

    // ---------------- randomised packets ----------------
    for (int i = 0; i < 6; i++) begin
      kind = $urandom_range(0, 3);
      sp   = $urandom_range(10, 100);
      st   = $urandom_range(420, 600);
      sel  = ($urandom_range(0, 1) != 0) ? $urandom_range(100, 200) : $urandom_range(45, 90);
      r    = ($urandom_range(0, 1) != 0) ? $urandom_range(100, 200) : $urandom_range(45, 90);
      l    = ($urandom_range(0, 1) != 0) ? $urandom_range(100, 200) : $urandom_range(45, 90);
      b    = ($urandom_range(0, 1) != 0) ? $urandom_range(100, 200) : $urandom_range(45, 90);
      f    = ($urandom_range(0, 1) != 0) ? $urandom_range(100, 200) : $urandom_range(45, 90);
      if (kind == 0) begin
        level(1'b0, st);  level(1'b1, sp);
        level(1'b0, sel); level(1'b1, sp);
        level(1'b0, r);   level(1'b1, sp);
        level(1'b0, $urandom_range(5, 35));
        level(1'b1, 30);
        m_err = 1'b1;
      end else begin
        mode = $urandom_range(0, 2);
        if (mode == 2 && m_valid) mode = 0;
        send_packet(st, sel, r, l, b, f, sp, mode);
      end
      check_regs("rand");
      if ($urandom_range(0, 1) != 0) ack_pulse();
      if ($urandom_range(0, 2) == 0) clear_status();
      check_regs("rand_post");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ir_receiver
`default_nettype wire
